serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_sub_pkg.sv | 17 +
 rtl/digit_subtractor.sv | 19 +
 rtl/serial_subtractor.sv | 106 ++++++++++
 tb/tb_serial_subtractor.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and parameter checks for the serial subtractor slice.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // WIDTH must be 1..64 and an exact multiple of DIGIT.
  function automatic bit params_legal(input int width, input int digit);
    if (width < 1 || width > 64) return 1'b0;
    if (digit < 1 || digit > width) return 1'b0;
    return (width % digit) == 0;
  endfunction

endpackage

// File: rtl/digit_subtractor.sv
// Combinational DIGIT-bit subtractor cell: diff = a - b - bin, bout = borrow out.
module digit_subtractor #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bin,
  output logic [DIGIT-1:0] diff,
  output logic             bout
);

  // One extra bit catches the borrow as the sign of the widened difference.
  logic [DIGIT:0] full;

  assign full = {1'b0, a} - {1'b0, b} - {{DIGIT{1'b0}}, bin};
  assign diff = full[DIGIT-1:0];
  assign bout = full[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: DIGIT bits of A - B - Bin per clock, LSB chunk first.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borr,
  output logic             Ovf,
  output logic             Zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (!params_legal(WIDTH, DIGIT)) begin : g_illegal
    $fatal(1, "serial_subtractor: illegal WIDTH=%0d DIGIT=%0d", WIDTH, DIGIT);
  end

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] diff_sh;
  logic [WIDTH-1:0] diff_next;
  logic             borrow;
  logic             a_msb;
  logic             b_msb;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] chunk_diff;
  logic             chunk_bout;

  digit_subtractor #(.DIGIT(DIGIT)) u_digit (
    .a    (a_sh[DIGIT-1:0]),
    .b    (b_sh[DIGIT-1:0]),
    .bin  (borrow),
    .diff (chunk_diff),
    .bout (chunk_bout)
  );

  // New chunk enters at the MSB end; after N chunks the register is fully aligned.
  assign diff_next = WIDTH'({chunk_diff, diff_sh} >> DIGIT);

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      diff_sh <= '0;
      borrow  <= 1'b0;
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
      cnt     <= '0;
      Diff    <= '0;
      Borr    <= 1'b0;
      Ovf     <= 1'b0;
      Zero    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sh    <= A;
            b_sh    <= B;
            borrow  <= Bin;
            a_msb   <= A[WIDTH-1];
            b_msb   <= B[WIDTH-1];
            diff_sh <= '0;
            cnt     <= '0;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh    <= a_sh >> DIGIT;
          b_sh    <= b_sh >> DIGIT;
          diff_sh <= diff_next;
          borrow  <= chunk_bout;
          cnt     <= cnt + CW'(1);
          // Result outputs change only here, so nothing partial is ever visible.
          if (cnt == LAST) begin
            state <= DONE;
            Diff  <= diff_next;
            Borr  <= chunk_bout;
            Ovf   <= (a_msb != b_msb) && (diff_next[WIDTH-1] != a_msb);
            Zero  <= (diff_next == '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: DIGIT 1/2/4 at WIDTH 8, plus the WIDTH 1 cell.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_v [3];
  logic [7:0] a_v     [3];
  logic [7:0] b_v     [3];
  logic       bin_v   [3];
  logic       busy_v  [3];
  logic       done_v  [3];
  logic [7:0] diff_v  [3];
  logic       borr_v  [3];
  logic       ovf_v   [3];
  logic       zero_v  [3];

  logic start_w, a_w, b_w, bin_w;
  logic busy_w, done_w, diff_w, borr_w, ovf_w, zero_w;

  int vectors     = 0;
  int miscompares = 0;

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start_v[0]), .A(a_v[0]), .B(b_v[0]), .Bin(bin_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .Diff(diff_v[0]), .Borr(borr_v[0]),
    .Ovf(ovf_v[0]), .Zero(zero_v[0])
  );

  serial_subtractor #(.WIDTH(8), .DIGIT(2)) u_d2 (
    .clk(clk), .rst(rst), .start(start_v[1]), .A(a_v[1]), .B(b_v[1]), .Bin(bin_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .Diff(diff_v[1]), .Borr(borr_v[1]),
    .Ovf(ovf_v[1]), .Zero(zero_v[1])
  );

  serial_subtractor #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .start(start_v[2]), .A(a_v[2]), .B(b_v[2]), .Bin(bin_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .Diff(diff_v[2]), .Borr(borr_v[2]),
    .Ovf(ovf_v[2]), .Zero(zero_v[2])
  );

  serial_subtractor #(.WIDTH(1), .DIGIT(1)) u_w1 (
    .clk(clk), .rst(rst), .start(start_w), .A(a_w), .B(b_w), .Bin(bin_w),
    .busy(busy_w), .done(done_w), .Diff(diff_w), .Borr(borr_w),
    .Ovf(ovf_w), .Zero(zero_w)
  );

  // Drives a start (caller sits just after a rising edge) and counts edges until done.
  task automatic run8(input int k, input logic [7:0] a, input logic [7:0] b,
                      input logic bin, output int lat);
    start_v[k] = 1'b1;
    a_v[k]     = a;
    b_v[k]     = b;
    bin_v[k]   = bin;
    lat        = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == 1) start_v[k] = 1'b0;
      if (done_v[k] === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (busy_v[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_v[0]); end
    vectors++; if (done_v[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b expected 0", done_v[0]); end
    vectors++; if (diff_v[0] !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_diff: got %h expected 00", diff_v[0]); end
    vectors++; if (borr_v[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_borr: got %b expected 0", borr_v[0]); end
    vectors++; if (ovf_v[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ovf: got %b expected 0", ovf_v[0]); end
    vectors++; if (zero_v[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_zero: got %b expected 0", zero_v[0]); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_digit1();
    int lat;
    run8(0, 8'd5, 8'd3, 1'b0, lat);
    vectors++; if (lat !== 9) begin miscompares++; $display("[TB] FAIL d1_5m3_latency: got %0d expected 9", lat); end
    vectors++; if (diff_v[0] !== 8'h02) begin miscompares++; $display("[TB] FAIL d1_5m3_diff: got %h expected 02", diff_v[0]); end
    vectors++; if (borr_v[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL d1_5m3_borr: got %b expected 0", borr_v[0]); end
    vectors++; if (ovf_v[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL d1_5m3_ovf: got %b expected 0", ovf_v[0]); end
    vectors++; if (zero_v[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL d1_5m3_zero: got %b expected 0", zero_v[0]); end
    // 127 - (-1) overflows signed and borrows unsigned
    run8(0, 8'h7F, 8'hFF, 1'b0, lat);
    vectors++; if (lat !== 9) begin miscompares++; $display("[TB] FAIL d1_7fmff_latency: got %0d expected 9", lat); end
    vectors++; if (diff_v[0] !== 8'h80) begin miscompares++; $display("[TB] FAIL d1_7fmff_diff: got %h expected 80", diff_v[0]); end
    vectors++; if (borr_v[0] !== 1'b1) begin miscompares++; $display("[TB] FAIL d1_7fmff_borr: got %b expected 1", borr_v[0]); end
    vectors++; if (ovf_v[0] !== 1'b1) begin miscompares++; $display("[TB] FAIL d1_7fmff_ovf: got %b expected 1", ovf_v[0]); end
  endtask

  task automatic test_ignore_start();
    int lat;
    start_v[0] = 1'b1; a_v[0] = 8'h10; b_v[0] = 8'h01; bin_v[0] = 1'b1;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == 1) start_v[0] = 1'b0;
      if (i == 3) begin
        vectors++; if (busy_v[0] !== 1'b1) begin miscompares++; $display("[TB] FAIL ign_busy: got %b expected 1", busy_v[0]); end
        vectors++; if (diff_v[0] !== 8'h80) begin miscompares++; $display("[TB] FAIL ign_diff_hold: got %h expected 80", diff_v[0]); end
        start_v[0] = 1'b1; a_v[0] = 8'hFF; b_v[0] = 8'h00; bin_v[0] = 1'b0;
      end
      if (i == 4) start_v[0] = 1'b0;
      if (done_v[0] === 1'b1) begin
        lat = i;
        break;
      end
    end
    vectors++; if (lat !== 9) begin miscompares++; $display("[TB] FAIL ign_latency: got %0d expected 9", lat); end
    vectors++; if (diff_v[0] !== 8'h0E) begin miscompares++; $display("[TB] FAIL ign_diff: got %h expected 0e", diff_v[0]); end
    vectors++; if (borr_v[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL ign_borr: got %b expected 0", borr_v[0]); end
    @(posedge clk); #1;
    vectors++; if (done_v[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL ign_done_width: got %b expected 0", done_v[0]); end
  endtask

  task automatic test_digit2();
    int lat;
    run8(1, 8'h00, 8'h01, 1'b0, lat);
    vectors++; if (lat !== 5) begin miscompares++; $display("[TB] FAIL d2_latency: got %0d expected 5", lat); end
    vectors++; if (diff_v[1] !== 8'hFF) begin miscompares++; $display("[TB] FAIL d2_diff: got %h expected ff", diff_v[1]); end
    vectors++; if (borr_v[1] !== 1'b1) begin miscompares++; $display("[TB] FAIL d2_borr: got %b expected 1", borr_v[1]); end
    vectors++; if (ovf_v[1] !== 1'b0) begin miscompares++; $display("[TB] FAIL d2_ovf: got %b expected 0", ovf_v[1]); end
  endtask

  task automatic test_back_to_back();
    int lat;
    run8(2, 8'h80, 8'h00, 1'b1, lat);
    vectors++; if (lat !== 3) begin miscompares++; $display("[TB] FAIL b2b_first_latency: got %0d expected 3", lat); end
    vectors++; if (diff_v[2] !== 8'h7F) begin miscompares++; $display("[TB] FAIL b2b_first_diff: got %h expected 7f", diff_v[2]); end
    vectors++; if (borr_v[2] !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_first_borr: got %b expected 0", borr_v[2]); end
    vectors++; if (ovf_v[2] !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_first_ovf: got %b expected 1", ovf_v[2]); end
    // Second start issued during the DONE cycle
    start_v[2] = 1'b1; a_v[2] = 8'h3C; b_v[2] = 8'h3C; bin_v[2] = 1'b0;
    @(posedge clk); #1;
    start_v[2] = 1'b0;
    vectors++; if (busy_v[2] !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_no_gap_busy: got %b expected 1", busy_v[2]); end
    vectors++; if (diff_v[2] !== 8'h7F) begin miscompares++; $display("[TB] FAIL b2b_diff_hold: got %h expected 7f", diff_v[2]); end
    lat = -1;
    for (int i = 2; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done_v[2] === 1'b1) begin
        lat = i;
        break;
      end
    end
    vectors++; if (lat !== 3) begin miscompares++; $display("[TB] FAIL b2b_second_latency: got %0d expected 3", lat); end
    vectors++; if (diff_v[2] !== 8'h00) begin miscompares++; $display("[TB] FAIL b2b_second_diff: got %h expected 00", diff_v[2]); end
    vectors++; if (zero_v[2] !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_second_zero: got %b expected 1", zero_v[2]); end
    vectors++; if (ovf_v[2] !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_second_ovf: got %b expected 0", ovf_v[2]); end
  endtask

  task automatic test_reset_abort();
    int seen;
    start_v[0] = 1'b1; a_v[0] = 8'h22; b_v[0] = 8'h11; bin_v[0] = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (i == 1) start_v[0] = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++; if (busy_v[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_busy: got %b expected 0", busy_v[0]); end
    vectors++; if (diff_v[0] !== 8'h00) begin miscompares++; $display("[TB] FAIL abort_diff: got %h expected 00", diff_v[0]); end
    vectors++; if (borr_v[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_borr: got %b expected 0", borr_v[0]); end
    vectors++; if (zero_v[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_zero: got %b expected 0", zero_v[0]); end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done_v[0] !== 1'b0) seen++;
    end
    vectors++; if (seen !== 0) begin miscompares++; $display("[TB] FAIL abort_no_done: got %0d done cycles expected 0", seen); end
  endtask

  task automatic test_reset_priority();
    rst = 1'b1;
    start_v[0] = 1'b1; a_v[0] = 8'd9; b_v[0] = 8'd4; bin_v[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    start_v[0] = 1'b0;
    vectors++; if (busy_v[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_prio_busy: got %b expected 0", busy_v[0]); end
    @(posedge clk); #1;
    vectors++; if (done_v[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_prio_done: got %b expected 0", done_v[0]); end
  endtask

  task automatic test_width1();
    logic [1:0] ab [4];
    logic [1:0] exp_db [4];
    int lat;
    ab[0] = 2'b00; exp_db[0] = 2'b00;
    ab[1] = 2'b01; exp_db[1] = 2'b11;
    ab[2] = 2'b10; exp_db[2] = 2'b10;
    ab[3] = 2'b11; exp_db[3] = 2'b00;
    for (int v = 0; v < 4; v++) begin
      start_w = 1'b1; a_w = ab[v][1]; b_w = ab[v][0]; bin_w = 1'b0;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
        @(posedge clk); #1;
        if (i == 1) start_w = 1'b0;
        if (done_w === 1'b1) begin
          lat = i;
          break;
        end
      end
      vectors++; if (lat !== 2) begin miscompares++; $display("[TB] FAIL w1_latency ab=%b: got %0d expected 2", ab[v], lat); end
      vectors++; if ({diff_w, borr_w} !== exp_db[v]) begin miscompares++; $display("[TB] FAIL w1_diff_borr ab=%b: got %b%b expected %b", ab[v], diff_w, borr_w, exp_db[v]); end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start_v[k] = 1'b0; a_v[k] = '0; b_v[k] = '0; bin_v[k] = 1'b0;
    end
    start_w = 1'b0; a_w = 1'b0; b_w = 1'b0; bin_w = 1'b0;
    test_reset();
    test_digit1();
    test_ignore_start();
    test_digit2();
    test_back_to_back();
    test_reset_abort();
    test_reset_priority();
    test_width1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
